// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer sequencer: steers capture writes into the back bank
// and swaps banks only when both the captured frame and the reader are at a frame boundary.
module fb_pingpong_ctrl #(
  parameter int c_nb_img_pxls = 13,
  parameter int c_img_pxls    = 4800,
  parameter int c_nb_drop     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     config_done,
  input  logic                     freeze,
  input  logic                     cap_we,
  input  logic [c_nb_img_pxls-1:0] cap_addr,
  input  logic                     disp_frame_start,
  input  logic                     disp_frame_end,
  output logic                     wea_bank0,
  output logic                     wea_bank1,
  output logic                     rd_bank,
  output logic                     wr_bank,
  output logic                     frame_ready,
  output logic [1:0]               state,
  output logic [c_nb_drop-1:0]     drop_cnt
);

  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_CAPTURE  = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  localparam logic [c_nb_img_pxls-1:0] c_first_addr = {c_nb_img_pxls{1'b0}};
  localparam logic [c_nb_img_pxls-1:0] c_last_addr  = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_drop-1:0]     c_drop_max   = {c_nb_drop{1'b1}};
  localparam logic [c_nb_drop-1:0]     c_drop_one   = {{(c_nb_drop-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 disp_busy_q, disp_busy_d;
  logic                 frame_ready_q, frame_ready_d;
  logic [c_nb_drop-1:0] drop_cnt_q, drop_cnt_d;

  logic sof_s, eof_s, swap_ok_s, cap_accept_s, swap_s, drop_inc_s;
  logic wea0_s, wea1_s;

  assign sof_s     = cap_we & (cap_addr == c_first_addr);
  assign eof_s     = cap_we & (cap_addr == c_last_addr);
  // An end pulse in the same cycle frees the reader bank in time for a swap.
  assign swap_ok_s = ~disp_busy_q | disp_frame_end;

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      disp_busy_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      drop_cnt_q    <= {c_nb_drop{1'b0}};
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      disp_busy_q   <= disp_busy_d;
      frame_ready_q <= frame_ready_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: begin
        if (config_done) state_d = S_WAIT_SOF;
        else             state_d = S_INIT;
      end
      S_WAIT_SOF: begin
        if (sof_s && !freeze) state_d = S_CAPTURE;
        else                  state_d = S_WAIT_SOF;
      end
      S_CAPTURE: begin
        if (eof_s) begin
          if (swap_ok_s) state_d = S_WAIT_SOF;
          else           state_d = S_HOLD;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_HOLD: begin
        if (swap_ok_s) state_d = S_WAIT_SOF;
        else           state_d = S_HOLD;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Per-state outputs: write gating, swap and drop events.
  always_comb begin
    cap_accept_s = 1'b0;
    swap_s       = 1'b0;
    drop_inc_s   = 1'b0;
    case (state_q)
      S_INIT: begin
        cap_accept_s = 1'b0;
      end
      S_WAIT_SOF: begin
        cap_accept_s = sof_s & ~freeze;
      end
      S_CAPTURE: begin
        cap_accept_s = 1'b1;
        if (eof_s) begin
          swap_s = swap_ok_s;
        end else begin
          drop_inc_s = sof_s;
        end
      end
      S_HOLD: begin
        swap_s     = swap_ok_s;
        drop_inc_s = sof_s;
      end
      default: begin
        cap_accept_s = 1'b0;
      end
    endcase
    // Explicit reset gating keeps the RAM strobes low for the whole reset pulse.
    wea0_s = ~rst & cap_accept_s & cap_we & ~wr_bank_q;
    wea1_s = ~rst & cap_accept_s & cap_we &  wr_bank_q;
  end

  // Bank pointers, reader tracking and drop counter next values.
  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_ready_d = frame_ready_q;
    drop_cnt_d    = drop_cnt_q;
    if (swap_s) begin
      rd_bank_d     = wr_bank_q;
      wr_bank_d     = ~wr_bank_q;
      frame_ready_d = 1'b1;
    end else begin
      frame_ready_d = frame_ready_q;
    end
    if (drop_inc_s && (drop_cnt_q != c_drop_max)) begin
      drop_cnt_d = drop_cnt_q + c_drop_one;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    if (disp_frame_start)    disp_busy_d = 1'b1;
    else if (disp_frame_end) disp_busy_d = 1'b0;
    else                     disp_busy_d = disp_busy_q;
  end

  assign wea_bank0   = wea0_s;
  assign wea_bank1   = wea1_s;
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = wr_bank_q;
  assign frame_ready = frame_ready_q;
  assign state       = state_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/fb_pingpong_ctrl.md
Name: fb_pingpong_ctrl

Overview:
- Sequences a ping-pong pair of frame buffers between the ov7670 capture path (writer) and the display/OLED readout path (reader).
- Gates the capture write strobe into the back bank, tracks whether the reader is mid-frame, and swaps banks only at frame boundaries, so the reader never sees a torn frame.
- Sits between the capture block and the two frame-buffer RAM write ports, and drives the read-bank select mux on the display side.

Parameters:
- c_nb_img_pxls, 13, width of capture pixel address.
- c_img_pxls, 4800, pixels per frame; last address = c_img_pxls-1.
- c_nb_drop, 8, width of dropped-frame counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- config_done  in  1  camera register configuration finished (level).
- freeze  in  1  level; stop starting new captures (button).
- cap_we  in  1  capture pixel write strobe.
- cap_addr  in  c_nb_img_pxls  capture pixel address.
- disp_frame_start  in  1  1-cycle pulse: reader begins a frame.
- disp_frame_end  in  1  1-cycle pulse: reader finished a frame.
- wea_bank0  out  1  write enable to bank 0 (combinational).
- wea_bank1  out  1  write enable to bank 1 (combinational).
- rd_bank  out  1  bank the reader must use (registered).
- wr_bank  out  1  bank currently written (registered).
- frame_ready  out  1  sticky: reader bank holds a complete frame.
- state  out  2  FSM state, for LEDs.
- drop_cnt  out  c_nb_drop  saturating count of discarded camera frames.

Behaviour:
- Reset (async, immediate): state=INIT(0), wr_bank=0, rd_bank=1, disp_busy=0, frame_ready=0, drop_cnt=0. wea_bank0/1=0 while rst is high.
- Derived signals:
  - sof = cap_we & (cap_addr==0).
  - eof = cap_we & (cap_addr==c_img_pxls-1).
- disp_busy (internal):
  - Set on disp_frame_start.
  - Cleared on disp_frame_end.
  - Start wins if both pulses arrive in the same cycle.
- cap_accept = (state==CAPTURE) | (state==WAIT_SOF & sof & ~freeze).
- wea_bankN = cap_accept & cap_we & (wr_bank==N). This path is zero-latency: address and data go straight to the RAM, so the first pixel of a frame is written.
- FSM:
  - INIT(0): go to WAIT_SOF when config_done=1.
  - WAIT_SOF(1):
    - On sof & ~freeze: go to CAPTURE. The addr-0 pixel is written this cycle.
    - While freeze=1: stay; sof is ignored and not counted as dropped.
  - CAPTURE(2):
    - On eof: the pixel is written; the frame is complete.
      - If swap_ok = ~disp_busy | disp_frame_end: swap (rd_bank<=wr_bank, wr_bank<=~wr_bank), set frame_ready=1, go to WAIT_SOF.
      - Otherwise go to HOLD.
    - On sof with addr 0 before eof (early vsync / short frame): restart the frame in the same bank, stay in CAPTURE, drop_cnt+1.
    - freeze does not abort a capture in progress.
  - HOLD(3):
    - No writes (wea=0).
    - Each sof seen: drop_cnt+1.
    - When ~disp_busy | disp_frame_end: swap as above, frame_ready=1, go to WAIT_SOF.
    - A sof in the swap cycle is dropped and counted; capture resumes from the next sof.
- Swap coincident with disp_frame_start: the swap still happens, disp_busy is set, and the reader reads the new rd_bank from its first pixel. The reader samples rd_bank on the cycle after its start pulse.
- drop_cnt saturates at all-ones.
- config_done falling after INIT has no effect; only rst returns the FSM to INIT.
- eof with cap_addr==0 is not possible (c_img_pxls>1).

Test Plan:
- Reset/config: assert rst → wea=0, rd_bank=1, wr_bank=0, state=0, drop_cnt=0. Raise config_done → state=1 next cycle.
- Clean swap: reader idle; drive a 4800-write frame addr 0..4799 → wea_bank0 high on all 4800 writes, wea_bank1 never. Cycle after addr 4799: rd_bank=0, wr_bank=1, frame_ready=1, state=1.
- Reader busy: pulse disp_frame_start, then a full frame → state=3 after eof, no writes. Drive 2 further sof → drop_cnt=2. Pulse disp_frame_end → swap next edge, state=1.
- Coincident end: reader busy; disp_frame_end in the same cycle as the addr-4799 write → immediate swap, state=1, never 3.
- Short frame: in CAPTURE at addr 1000, issue addr 0 write → state stays 2, drop_cnt+1, that write goes to the same wr_bank.
- Freeze: freeze=1 in WAIT_SOF; sof → no wea, state=1, drop_cnt unchanged. freeze=1 asserted mid-CAPTURE → frame completes and swaps. Async rst mid-CAPTURE → wea drops to 0 within the same cycle, all state returns to reset values.
